// File: rtl/config_pkg.sv
// Shared types and constants for the instrumentation reconfiguration path.
package config_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEFAULT_IDLE_ID = 8'hFF;

  typedef enum logic [2:0] {TRACE, DRAIN, LOAD, HDR, SEND, GAP} state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } frame_byte_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; flush empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/reconfig_sequencer.sv
// Buffers host config frames and replays each as a stall-free burst on the
// broadcast config bus during a quiesced (tracing=0) window.
module reconfig_sequencer
  import config_pkg::*;
#(
  parameter int                FIFO_DEPTH   = 16,
  parameter logic [BYTE_W-1:0] IDLE_ID      = DEFAULT_IDLE_ID,
  parameter int                DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tracing_req,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [BYTE_W-1:0] host_data,
  input  logic              host_last,
  output logic              tracing,
  output logic [BYTE_W-1:0] configId,
  output logic [BYTE_W-1:0] configData,
  output logic              busy,
  output logic              err
);
  localparam int PW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t            state;
  logic [BYTE_W-1:0] target_id;
  logic              drop_frame;
  logic              discarding;
  logic [PW-1:0]     frames_pending;
  logic [DW-1:0]     drain_cnt;

  frame_byte_t       head;
  logic [BYTE_W:0]   head_raw;
  logic              full, empty, accept, push, pop, pop_last, deadlock;

  assign head       = head_raw;
  assign host_ready = !rst && !full;
  assign accept     = host_valid && host_ready;
  assign push       = accept && !discarding;
  assign pop        = ((state == HDR) || (state == SEND)) && !empty;
  assign pop_last   = pop && head.last;
  // A full buffer with no complete frame can never drain on its own.
  assign deadlock   = full && (frames_pending == '0);

  sync_fifo #(.WIDTH(BYTE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (deadlock),
    .push  (push),
    .wdata ({host_last, host_data}),
    .pop   (pop),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst || deadlock) frames_pending <= '0;
    else begin
      case ({push && host_last, pop_last})
        2'b10:   frames_pending <= frames_pending + 1'b1;
        2'b01:   frames_pending <= frames_pending - 1'b1;
        default: frames_pending <= frames_pending;
      endcase
    end
  end

  // Swallow the tail of an oversized frame, up to and including its last byte.
  always_ff @(posedge clk) begin
    if (rst)                        discarding <= 1'b0;
    else if (deadlock)              discarding <= 1'b1;
    else if (accept && host_last)   discarding <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      tracing    <= 1'b0;
      configId   <= IDLE_ID;
      configData <= '0;
      busy       <= 1'b1;
      err        <= 1'b0;
      drain_cnt  <= '0;
      target_id  <= IDLE_ID;
      drop_frame <= 1'b0;
    end else begin
      configId   <= IDLE_ID;
      configData <= '0;
      if (deadlock) err <= 1'b1;
      case (state)
        TRACE: begin
          if (!tracing_req) begin
            state     <= DRAIN;
            tracing   <= 1'b0;
            busy      <= 1'b1;
            drain_cnt <= '0;
          end else tracing <= 1'b1;
        end
        DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= LOAD;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        LOAD: begin
          if (tracing_req) begin
            state <= TRACE;
            busy  <= 1'b0;
          end else if (frames_pending != '0) state <= HDR;
        end
        HDR: begin
          if (drop_frame) begin
            if (head.last) begin
              drop_frame <= 1'b0;
              state      <= GAP;
            end
          end else begin
            target_id <= head.data;
            if (head.last || head.data == IDLE_ID) begin
              err <= 1'b1;
              if (head.last) state <= GAP;
              else drop_frame <= 1'b1;
            end else state <= SEND;
          end
        end
        SEND: begin
          configId   <= target_id;
          configData <= head.data;
          if (head.last) state <= GAP;
        end
        GAP:     state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_reconfig_sequencer.sv
// Directed bench for reconfig_sequencer: per-cycle bus log checked against
// hand-computed burst positions.
module tb_reconfig_sequencer;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst, tracing_req, host_valid, host_last;
  logic [7:0] host_data;
  logic       host_ready, tracing, busy, err;
  logic [7:0] configId, configData;

  int checks = 0;
  int errors = 0;
  logic [7:0] id_log[$];
  logic [7:0] dat_log[$];
  logic       trc_log[$];
  logic       busy_log[$];

  reconfig_sequencer #(.FIFO_DEPTH(16), .IDLE_ID(8'hFF), .DRAIN_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tracing_req (tracing_req),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_data   (host_data),
    .host_last   (host_last),
    .tracing     (tracing),
    .configId    (configId),
    .configData  (configData),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    id_log.push_back(configId);
    dat_log.push_back(configData);
    trc_log.push_back(tracing);
    busy_log.push_back(busy);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int budget = 0;
    host_valid = 1'b1;
    host_data  = d;
    host_last  = l;
    while (!host_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (budget == 50) chk("host_ready_wait", host_ready, 1);
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic push_frame(input bq_t q);
    for (int i = 0; i < q.size(); i++) push_byte(q[i], i == q.size() - 1);
  endtask

  task automatic chk_idle(input string tag, input int from, input int to);
    for (int i = from; i <= to; i++) chk(tag, id_log[i], 8'hFF);
  endtask

  // Payload bytes q[1..] on consecutive cycles from 'start', then idle.
  task automatic chk_burst(input string tag, input int start, input logic [7:0] id, input bq_t q);
    for (int i = 1; i < q.size(); i++) begin
      chk({tag, "_id"}, id_log[start+i-1], id);
      chk({tag, "_data"}, dat_log[start+i-1], q[i]);
    end
    chk({tag, "_end"}, id_log[start+q.size()-1], 8'hFF);
  endtask

  initial begin
    bq_t fr, fa, fb, fx, fy;
    int  b;
    rst = 1'b1; tracing_req = 1'b1; host_valid = 1'b0; host_data = '0; host_last = 1'b0;

    // Reset state
    tick();
    chk("rst_tracing", tracing, 0);
    chk("rst_configId", configId, 8'hFF);
    chk("rst_configData", configData, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", host_ready, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", host_ready, 1);
    chk("tracing_1cyc", tracing, 0);
    tick();
    chk("tracing_2cyc", tracing, 1);
    chk("busy_trace", busy, 0);

    // Frame buffered during TRACE, replayed after the drain window
    fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    push_frame(fr);
    chk("trace_hold_id", configId, 8'hFF);
    tracing_req = 1'b0;
    b = id_log.size();
    repeat (14) tick();
    chk("drain_tracing", trc_log[b], 0);
    chk("drain_busy", busy_log[b], 1);
    chk_idle("drain_idle", b, b + 6);
    chk_burst("first", b + 7, 8'h03, fr);

    // Two back-to-back frames to the same ID
    fa = '{8'h03, 8'h55, 8'h66, 8'h77, 8'h88};
    fb = '{8'h03, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    b = id_log.size();
    push_frame(fa);
    push_frame(fb);
    repeat (12) tick();
    chk_idle("b2b_pre", b, b + 6);
    chk_burst("b2b_a", b + 7, 8'h03, fa);
    chk_idle("b2b_gap", b + 11, b + 13);
    chk_burst("b2b_b", b + 14, 8'h03, fb);

    // Host stalls inside a frame
    fr = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    b = id_log.size();
    push_byte(8'h03, 1'b0);
    repeat (3) tick();
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    repeat (5) tick();
    push_byte(8'h03, 1'b0);
    push_byte(8'h04, 1'b1);
    repeat (8) tick();
    chk_idle("stall_pre", b, b + 14);
    chk_burst("stall", b + 15, 8'h03, fr);

    // tracing_req rises mid-burst; second frame held for next window
    fx = '{8'h07, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    fy = '{8'h08, 8'hB1};
    b = id_log.size();
    push_frame(fx);
    push_frame(fy);
    tick();
    tick();
    tracing_req = 1'b1;
    repeat (15) tick();
    chk_burst("midreq", b + 7, 8'h07, fx);
    chk("midreq_trc_load", trc_log[b+12], 0);
    chk("midreq_busy", busy_log[b+12], 0);
    chk("midreq_trc_on", trc_log[b+13], 1);
    chk_idle("held_frame", b + 11, b + 23);
    chk("err_clean", err, 0);

    tracing_req = 1'b0;
    b = id_log.size();
    repeat (12) tick();
    chk_idle("held_pre", b, b + 6);
    chk_burst("held", b + 7, 8'h08, fy);

    // Oversized 17-byte frame: error, flush, discard tail
    b = id_log.size();
    push_byte(8'h09, 1'b0);
    for (int i = 1; i < 16; i++) push_byte(8'(i), 1'b0);
    push_byte(8'h10, 1'b1);
    repeat (3) tick();
    chk("ovf_err", err, 1);
    chk("ovf_ready", host_ready, 1);
    chk_idle("ovf_idle", b, id_log.size() - 1);
    fr = '{8'h05, 8'hAA};
    b = id_log.size();
    push_frame(fr);
    repeat (5) tick();
    chk_idle("post_ovf_pre", b, b + 3);
    chk_burst("post_ovf", b + 4, 8'h05, fr);
    chk("err_sticky", err, 1);

    // Reset in the middle of a burst
    fr = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    b = id_log.size();
    push_frame(fr);
    repeat (4) tick();
    chk("midrst_active", id_log[b+7], 8'h03);
    rst = 1'b1;
    tick();
    chk("midrst_id", configId, 8'hFF);
    chk("midrst_err", err, 0);
    rst = 1'b0;
    repeat (10) tick();
    chk_idle("midrst_after", b + 9, id_log.size() - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reconfig_sequencer.md
# reconfig_sequencer

Drives the broadcast instrumentation configuration bus (`tracing`, `configId`, `configData`) shared by the data packer and the other configurable trace blocks. It accepts configuration frames from the host as a byte stream, buffers each frame completely, and quiesces tracing before use. It then replays each frame as an unbroken burst of bytes with the target `configId` held constant. Receiving blocks advance an internal byte counter on every cycle their ID is present and reset it when the ID changes, so bursts must never stall and must be separated by an idle ID.

## Interface
Parameters:
- `FIFO_DEPTH`, 16 — byte buffer entries; also the maximum frame size (header + payload).
- `IDLE_ID`, 8'hFF — `configId` driven when no frame is being sent; no block may own this ID.
- `DRAIN_CYCLES`, 4 — cycles with `tracing=0` and `IDLE_ID` before the first burst.

Ports:
- `clk` in 1 — sole clock.
- `rst` in 1 — synchronous, active-high reset.
- `tracing_req` in 1 — host requests tracing; 0 requests a reconfiguration window.
- `host_valid` in 1 — host byte valid.
- `host_ready` out 1 — buffer can accept a byte.
- `host_data` in 8 — frame byte; the first byte of a frame is the target `configId`, the rest are payload.
- `host_last` in 1 — marks the final byte of a frame.
- `tracing` out 1 — global tracing enable to the trace blocks.
- `configId` out 8 — broadcast config target.
- `configData` out 8 — broadcast config byte.
- `busy` out 1 — high in every state except TRACE.
- `err` out 1 — sticky error flag; cleared only by `rst`.

## Operation
- The buffer is a FIFO_DEPTH x 9-bit FIFO holding {last, data}.
- A host byte is accepted on `host_valid && host_ready`. `host_ready = !full`, in all states.
- `frames_pending` counts complete frames in the buffer:
  - +1 when a byte with last=1 is accepted;
  - −1 when that byte is popped;
  - simultaneous +1/−1 leaves it unchanged.
- States (shared enum):
  - **TRACE**: `tracing` is driven high. Exit to DRAIN when `tracing_req`=0.
  - **DRAIN**: count DRAIN_CYCLES cycles, then go to LOAD.
  - **LOAD**:
    - If `tracing_req`=1, go to TRACE; pending frames stay buffered for the next window.
    - Otherwise, if `frames_pending`>0, go to HDR.
  - **HDR**: pop the header into `target_id`.
    - If header last=1 (zero payload), or header == IDLE_ID: set `err`, drop the frame (pop through its last byte), then go to GAP.
    - Otherwise go to SEND.
  - **SEND**: pop one payload byte per cycle and register `configId<=target_id`, `configData<=byte`.
    - No stall is possible, because the whole frame is already buffered.
    - On the last byte, go to GAP.
    - `tracing_req` rising during SEND does not interrupt the burst.
  - **GAP**: one cycle of `configId=IDLE_ID`, then go to LOAD.
- Deadlock guard: if the FIFO is full and `frames_pending`==0 (frame longer than FIFO_DEPTH), in any state:
  - set `err`;
  - flush the FIFO;
  - discard further bytes until the next byte with last=1 is accepted.
- Outside SEND, `configId`=IDLE_ID and `configData`=0.

## Timing
- All outputs are registered.
- Reset values:
  - `tracing`=0, `configId`=IDLE_ID, `configData`=0, `err`=0, `busy`=1;
  - state=LOAD, FIFO empty;
  - `host_ready`=0 during the reset cycle, 1 afterwards.
- `tracing_req` falls at edge t → `tracing`=0 at t+1.
  - The first HDR is at t+1+DRAIN_CYCLES+1 at the earliest.
- Frame with P payload bytes, pending in LOAD at cycle c:
  - HDR at c+1;
  - `configId`/`configData` valid for cycles c+3 … c+2+P, exactly P contiguous cycles;
  - IDLE_ID at c+3+P.
- Back-to-back frames:
  - consecutive bursts are separated by ≥3 idle-ID cycles (GAP, LOAD, HDR);
  - the ID always changes between bursts, even for the same target.
- LOAD → TRACE: `tracing`=1 one cycle after TRACE is entered.
- Reset mid-SEND:
  - the burst is truncated, `configId` returns to IDLE_ID, and the buffer is cleared;
  - the receiving block's byte counter resets because the ID changed.

## Structure
- `config_pkg`:
  - state enum {TRACE, DRAIN, LOAD, HDR, SEND, GAP};
  - default IDLE_ID constant;
  - the frame byte width (8).
- Sub-module `sync_fifo` (parameterised width and depth, with full, empty and flush) holds the byte buffer.
- The FSM, `frames_pending` counter, drain counter and deadlock guard live in the top module.

## Test plan
- Reset with `tracing_req`=1 and no frames → `tracing`=1 two cycles after reset release; `configId`=8'hFF throughout.
- `tracing_req`=0, then frame {8'h03, 8'h11, 8'h22, 8'h33, 8'h44} → after DRAIN, `configId`=3 for exactly 4 consecutive cycles with data 11/22/33/44; then 8'hFF.
- Two frames to ID 3, queued back to back → two 4-cycle bursts separated by ≥3 cycles of 8'hFF.
- Host stalls (`host_valid` gaps) mid-frame → no burst starts until `host_last` is accepted; the burst is still contiguous.
- `tracing_req` rises during a 4-byte burst → the burst completes, then GAP, LOAD, and `tracing`=1; a second queued frame is held until the next window.
- 17-byte frame with FIFO_DEPTH=16 → `err`=1, FIFO flushed, no burst emitted. A following valid frame {8'h05, 8'hAA} → `configId`=5 for 1 cycle.
